sprite_motion_array: RTL and testbench

Keyboard-driven motion engine for NUM_SPRITES independent sprites on the 640x480 VGA frame. Each sprite has its own key map, supports direct or momentum-based motion, is clamped to the screen edges, and reverts on sprite-to-sprite collision. Positions update once per frame, triggered by the VGA vertical sync. Outputs feed the color mapper directly, replacing the single-purpose fixed-key ball movers.

---
 rtl/sprite_motion_if.sv | 30 +++
 rtl/sprite_motion_array.sv | 219 +++++++++++++++++++++
 tb/tb_sprite_motion_array.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/sprite_motion_if.sv
// Bus bundle between the keyboard/VGA side and the sprite motion engine.
// master: drives vs, keycodes, keymap and the spawn centres, and receives the sprite state.
// slave:  the motion engine, which consumes those inputs and drives pos/size/flags.
interface sprite_motion_if #(
  parameter int unsigned NUM_SPRITES = 2,
  parameter int unsigned NUM_KEYS    = 6
);
  logic                      vs;
  logic [8*NUM_KEYS-1:0]     keycodes;
  logic [32*NUM_SPRITES-1:0] keymap;
  logic [10*NUM_SPRITES-1:0] start_x;
  logic [10*NUM_SPRITES-1:0] start_y;
  logic [10*NUM_SPRITES-1:0] pos_x;
  logic [10*NUM_SPRITES-1:0] pos_y;
  logic [10*NUM_SPRITES-1:0] size;
  logic [NUM_SPRITES-1:0]    wall_hit;
  logic [NUM_SPRITES-1:0]    collide;
  logic                      frame_done;
  logic                      valid;

  modport master (
    output vs, keycodes, keymap, start_x, start_y,
    input  pos_x, pos_y, size, wall_hit, collide, frame_done, valid
  );

  modport slave (
    input  vs, keycodes, keymap, start_x, start_y,
    output pos_x, pos_y, size, wall_hit, collide, frame_done, valid
  );
endinterface

// File: rtl/sprite_motion_array.sv
// Per-frame keyboard-driven motion engine for NUM_SPRITES sprites on a VGA frame.
// Ports: clk, rst_n (async active-low), bus (sprite_motion_if.slave):
//   in  vs, keycodes, keymap, start_x, start_y
//   out pos_x, pos_y, size, wall_hit (pulse), collide (level), frame_done (pulse), valid
// A rising edge of vs seen in IDLE runs UPDATE -> CHECK -> COMMIT; results land
// on the edge that ends COMMIT.
module sprite_motion_array #(
  parameter int unsigned NUM_SPRITES = 2,
  parameter int unsigned NUM_KEYS    = 6,
  parameter int unsigned SCREEN_W    = 640,
  parameter int unsigned SCREEN_H    = 480,
  parameter int unsigned SPRITE_S    = 4,
  parameter int unsigned MAX_SPEED   = 3,
  parameter int unsigned MOMENTUM    = 0
) (
  input  logic           clk,
  input  logic           rst_n,
  sprite_motion_if.slave bus
);
  localparam int unsigned PW = 10;
  localparam int unsigned CW = 12;
  localparam int unsigned DW = PW + 1;
  localparam int unsigned VW = 4;
  localparam logic signed [VW-1:0] VMAX    = VW'(MAX_SPEED);
  localparam logic signed [CW-1:0] LO      = CW'(SPRITE_S);
  localparam logic signed [CW-1:0] HI_X    = CW'(SCREEN_W - 1 - SPRITE_S);
  localparam logic signed [CW-1:0] HI_Y    = CW'(SCREEN_H - 1 - SPRITE_S);
  localparam logic [DW-1:0]        MIN_SEP = DW'(2 * SPRITE_S);

  typedef enum logic [2:0] {S_INIT, S_IDLE, S_UPDATE, S_CHECK, S_COMMIT} state_t;

  state_t                      state_q, state_d;
  logic                        vs_q;
  logic [PW*NUM_SPRITES-1:0]   pos_x_q, pos_y_q;
  logic signed [VW-1:0]        vel_x_q [NUM_SPRITES];
  logic signed [VW-1:0]        vel_y_q [NUM_SPRITES];
  logic [PW-1:0]               cand_x_q [NUM_SPRITES];
  logic [PW-1:0]               cand_y_q [NUM_SPRITES];
  logic [PW-1:0]               cand_x_d [NUM_SPRITES];
  logic [PW-1:0]               cand_y_d [NUM_SPRITES];
  logic signed [VW-1:0]        cvel_x_q [NUM_SPRITES];
  logic signed [VW-1:0]        cvel_y_q [NUM_SPRITES];
  logic signed [VW-1:0]        cvel_x_d [NUM_SPRITES];
  logic signed [VW-1:0]        cvel_y_d [NUM_SPRITES];
  logic [NUM_SPRITES-1:0]      wall_d, wall_q, coll_d, coll_q;
  logic [NUM_SPRITES-1:0]      wall_hit_q, collide_q;
  logic                        frame_done_q, valid_q;

  // A direction is held when its non-zero code appears in any keycode slot.
  function automatic logic key_held(input logic [7:0] code, input logic [8*NUM_KEYS-1:0] keys);
    logic hit;
    hit = 1'b0;
    for (int k = 0; k < NUM_KEYS; k++)
      if (code != 8'h00 && keys[8*k +: 8] == code) hit = 1'b1;
    return hit;
  endfunction

  // Opposing keys cancel; momentum mode ramps by one and decays toward zero.
  function automatic logic signed [VW-1:0] next_vel(input logic signed [VW-1:0] v,
                                                    input logic pos, input logic neg);
    logic                 p, n;
    logic signed [VW-1:0] r;
    p = pos & ~neg;
    n = neg & ~pos;
    r = '0;
    if (MOMENTUM == 0) begin
      if (p)      r = VMAX;
      else if (n) r = -VMAX;
    end else begin
      if (p)                 r = (v >= VMAX)  ? VMAX  : v + 4'sd1;
      else if (n)            r = (v <= -VMAX) ? -VMAX : v - 4'sd1;
      else if (v > 4'sd0)    r = v - 4'sd1;
      else if (v < 4'sd0)    r = v + 4'sd1;
    end
    return r;
  endfunction

  // Returns {clamped, position} with the candidate saturated to [LO, hi].
  function automatic logic [PW:0] clamp(input logic signed [CW-1:0] c,
                                        input logic signed [CW-1:0] hi);
    if (c < LO) return {1'b1, LO[PW-1:0]};
    if (c > hi) return {1'b1, hi[PW-1:0]};
    return {1'b0, c[PW-1:0]};
  endfunction

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_INIT;
    else        state_q <= state_d;
  end

  // Next-state logic; ticks outside IDLE are simply not looked at.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_INIT:   state_d = S_IDLE;
      S_IDLE:   if (!vs_q && bus.vs) state_d = S_UPDATE;
      S_UPDATE: state_d = S_CHECK;
      S_CHECK:  state_d = S_COMMIT;
      S_COMMIT: state_d = S_IDLE;
      default:  state_d = S_INIT;
    endcase
  end

  // Candidate velocity/position per sprite with edge clamping.
  always_comb begin
    logic [31:0]          km;
    logic signed [VW-1:0] vx, vy;
    logic signed [CW-1:0] cx, cy;
    logic [PW:0]          rx, ry;
    km = '0; vx = '0; vy = '0; cx = '0; cy = '0; rx = '0; ry = '0;
    wall_d = '0;
    for (int i = 0; i < NUM_SPRITES; i++) begin
      km = bus.keymap[32*i +: 32];
      vx = next_vel(vel_x_q[i], key_held(km[7:0], bus.keycodes), key_held(km[15:8], bus.keycodes));
      vy = next_vel(vel_y_q[i], key_held(km[23:16], bus.keycodes), key_held(km[31:24], bus.keycodes));
      cx = $signed({2'b00, pos_x_q[PW*i +: PW]}) + $signed({{(CW-VW){vx[VW-1]}}, vx});
      cy = $signed({2'b00, pos_y_q[PW*i +: PW]}) + $signed({{(CW-VW){vy[VW-1]}}, vy});
      rx = clamp(cx, HI_X);
      ry = clamp(cy, HI_Y);
      cand_x_d[i] = rx[PW-1:0];
      cand_y_d[i] = ry[PW-1:0];
      cvel_x_d[i] = rx[PW] ? '0 : vx;
      cvel_y_d[i] = ry[PW] ? '0 : vy;
      wall_d[i]   = rx[PW] | ry[PW];
    end
  end

  // Pairwise box overlap on the candidate centres.
  always_comb begin
    logic signed [DW-1:0] dx, dy;
    logic [DW-1:0]        adx, ady;
    dx = '0; dy = '0; adx = '0; ady = '0;
    coll_d = '0;
    for (int i = 0; i < NUM_SPRITES; i++) begin
      for (int j = 0; j < NUM_SPRITES; j++) begin
        if (i != j) begin
          dx  = $signed({1'b0, cand_x_q[i]}) - $signed({1'b0, cand_x_q[j]});
          dy  = $signed({1'b0, cand_y_q[i]}) - $signed({1'b0, cand_y_q[j]});
          adx = dx[DW-1] ? -dx : dx;
          ady = dy[DW-1] ? -dy : dy;
          if (adx < MIN_SEP && ady < MIN_SEP) coll_d[i] = 1'b1;
        end
      end
    end
  end

  // Datapath registers; an overlapping sprite keeps its old position and stops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_q         <= 1'b1;
      pos_x_q      <= '0;
      pos_y_q      <= '0;
      wall_q       <= '0;
      coll_q       <= '0;
      wall_hit_q   <= '0;
      collide_q    <= '0;
      frame_done_q <= 1'b0;
      valid_q      <= 1'b0;
      for (int i = 0; i < NUM_SPRITES; i++) begin
        vel_x_q[i]  <= '0;
        vel_y_q[i]  <= '0;
        cand_x_q[i] <= '0;
        cand_y_q[i] <= '0;
        cvel_x_q[i] <= '0;
        cvel_y_q[i] <= '0;
      end
    end else begin
      vs_q         <= bus.vs;
      frame_done_q <= 1'b0;
      wall_hit_q   <= '0;
      case (state_q)
        S_INIT: begin
          pos_x_q <= bus.start_x;
          pos_y_q <= bus.start_y;
          valid_q <= 1'b1;
        end
        S_UPDATE: begin
          wall_q <= wall_d;
          for (int i = 0; i < NUM_SPRITES; i++) begin
            cand_x_q[i] <= cand_x_d[i];
            cand_y_q[i] <= cand_y_d[i];
            cvel_x_q[i] <= cvel_x_d[i];
            cvel_y_q[i] <= cvel_y_d[i];
          end
        end
        S_CHECK: coll_q <= coll_d;
        S_COMMIT: begin
          for (int i = 0; i < NUM_SPRITES; i++) begin
            if (coll_q[i]) begin
              vel_x_q[i] <= '0;
              vel_y_q[i] <= '0;
            end else begin
              pos_x_q[PW*i +: PW] <= cand_x_q[i];
              pos_y_q[PW*i +: PW] <= cand_y_q[i];
              vel_x_q[i]          <= cvel_x_q[i];
              vel_y_q[i]          <= cvel_y_q[i];
            end
          end
          collide_q    <= coll_q;
          wall_hit_q   <= wall_q;
          frame_done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  for (genvar g = 0; g < NUM_SPRITES; g++) begin : g_size
    assign bus.size[PW*g +: PW] = PW'(SPRITE_S);
  end

  assign bus.pos_x      = pos_x_q;
  assign bus.pos_y      = pos_y_q;
  assign bus.wall_hit   = wall_hit_q;
  assign bus.collide    = collide_q;
  assign bus.frame_done = frame_done_q;
  assign bus.valid      = valid_q;
endmodule

// File: tb/tb_sprite_motion_array.sv
// Bench for sprite_motion_array: one direct-motion and one momentum instance
// share clock, reset and stimulus; expected frame results are queued per
// instance when a frame is launched and checked when frame_done arrives.
module tb_sprite_motion_array;
  localparam int unsigned NS = 2;

  typedef struct packed {
    logic [19:0] px;
    logic [19:0] py;
    logic [1:0]  wall;
    logic [1:0]  coll;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #10 clk = ~clk;

  sprite_motion_if #(.NUM_SPRITES(NS), .NUM_KEYS(6)) ifa ();
  sprite_motion_if #(.NUM_SPRITES(NS), .NUM_KEYS(6)) ifb ();

  sprite_motion_array #(.NUM_SPRITES(NS), .NUM_KEYS(6), .SCREEN_W(640), .SCREEN_H(480),
    .SPRITE_S(4), .MAX_SPEED(3), .MOMENTUM(0)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa.slave));
  sprite_motion_array #(.NUM_SPRITES(NS), .NUM_KEYS(6), .SCREEN_W(640), .SCREEN_H(480),
    .SPRITE_S(4), .MAX_SPEED(3), .MOMENTUM(1)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb.slave));

  exp_t qa[$];
  exp_t qb[$];
  int   vectors = 0;
  int   miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  function automatic exp_t mk(input int x0, input int y0, input int x1, input int y1,
                              input logic [1:0] w, input logic [1:0] c);
    exp_t e;
    e.px = {10'(x1), 10'(x0)};
    e.py = {10'(y1), 10'(y0)};
    e.wall = w;
    e.coll = c;
    return e;
  endfunction

  task automatic cmp_out(input string tag, input exp_t e, input logic [19:0] px,
                         input logic [19:0] py, input logic [1:0] w, input logic [1:0] c);
    logic [19:0] ex, ey;
    ex = e.px;
    ey = e.py;
    chk({tag, ".x0"}, 32'(px[9:0]), 32'(ex[9:0]));
    chk({tag, ".x1"}, 32'(px[19:10]), 32'(ex[19:10]));
    chk({tag, ".y0"}, 32'(py[9:0]), 32'(ey[9:0]));
    chk({tag, ".y1"}, 32'(py[19:10]), 32'(ey[19:10]));
    chk({tag, ".wall"}, 32'(w), 32'(e.wall));
    chk({tag, ".coll"}, 32'(c), 32'(e.coll));
  endtask

  task automatic set_start(input int x0, input int y0, input int x1, input int y1);
    ifa.start_x = {10'(x1), 10'(x0)};
    ifa.start_y = {10'(y1), 10'(y0)};
    ifb.start_x = ifa.start_x;
    ifb.start_y = ifa.start_y;
  endtask

  task automatic set_vs(input logic v);
    ifa.vs = v;
    ifb.vs = v;
  endtask

  task automatic set_keys(input logic [47:0] k);
    ifa.keycodes = k;
    ifb.keycodes = k;
  endtask

  // Hold reset for a cycle, check reset values, release and check the INIT load.
  task automatic reset_and_load(input string tag, input int x0, input int y0,
                                input int x1, input int y1);
    set_start(x0, y0, x1, y1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk({tag, ".rst_valid"}, 32'({ifa.valid, ifb.valid}), 32'd0);
    chk({tag, ".rst_pos"}, 32'(ifa.pos_x | ifa.pos_y | ifb.pos_x | ifb.pos_y), 32'd0);
    chk({tag, ".rst_flags"}, 32'({ifa.frame_done, ifa.collide, ifa.wall_hit,
                                  ifb.frame_done, ifb.collide, ifb.wall_hit}), 32'd0);
    chk({tag, ".rst_size"}, 32'(ifa.size), 32'd4100);
    rst_n = 1'b1;
    #1;
    chk({tag, ".valid_pre"}, 32'(ifa.valid), 32'd0);
    @(posedge clk); #1;
    chk({tag, ".valid"}, 32'({ifa.valid, ifb.valid}), 32'd3);
    cmp_out({tag, ".init_a"}, mk(x0, y0, x1, y1, 2'b00, 2'b00),
            ifa.pos_x, ifa.pos_y, ifa.wall_hit, ifa.collide);
    cmp_out({tag, ".init_b"}, mk(x0, y0, x1, y1, 2'b00, 2'b00),
            ifb.pos_x, ifb.pos_y, ifb.wall_hit, ifb.collide);
  endtask

  // One vs rising edge with the given keys; checks latency, results and pulse width.
  task automatic run_frame(input string tag, input logic [47:0] keys,
                           input exp_t ea, input exp_t eb);
    int   n;
    exp_t ga, gb;
    qa.push_back(ea);
    qb.push_back(eb);
    set_vs(1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    set_keys(keys);
    set_vs(1'b1);
    n = 0;
    while (n < 8 && ifa.frame_done !== 1'b1) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, ".latency"}, 32'(n), 32'd4);
    chk({tag, ".done_b"}, 32'(ifb.frame_done), 32'd1);
    ga = qa.pop_front();
    gb = qb.pop_front();
    cmp_out({tag, ".a"}, ga, ifa.pos_x, ifa.pos_y, ifa.wall_hit, ifa.collide);
    cmp_out({tag, ".b"}, gb, ifb.pos_x, ifb.pos_y, ifb.wall_hit, ifb.collide);
    @(posedge clk); #1;
    chk({tag, ".pulse"}, 32'({ifa.frame_done, ifb.frame_done, ifa.wall_hit, ifb.wall_hit}), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int mx[5];
    int mr[3];
    mx = '{101, 103, 106, 109, 112};
    mr = '{114, 115, 115};
    rst_n = 1'b0;
    set_vs(1'b1);
    set_keys(48'h0);
    ifa.keymap = 64'h5251504F_1A160407;
    ifb.keymap = 64'h5251504F_1A160407;

    // Idle frames: nothing moves.
    reset_and_load("boot", 100, 200, 300, 300);
    for (int f = 0; f < 10; f++)
      run_frame("idle", 48'h0, mk(100, 200, 300, 300, 2'b00, 2'b00),
                mk(100, 200, 300, 300, 2'b00, 2'b00));

    // Right key on sprite 0, then release, then opposing keys plus sprite 1 down.
    for (int f = 0; f < 5; f++)
      run_frame("right", 48'h07, mk(100 + 3 * (f + 1), 200, 300, 300, 2'b00, 2'b00),
                mk(mx[f], 200, 300, 300, 2'b00, 2'b00));
    for (int f = 0; f < 3; f++)
      run_frame("release", 48'h0, mk(115, 200, 300, 300, 2'b00, 2'b00),
                mk(mr[f], 200, 300, 300, 2'b00, 2'b00));
    run_frame("both", 48'h51_04_07, mk(115, 200, 300, 303, 2'b00, 2'b00),
              mk(115, 200, 300, 301, 2'b00, 2'b00));

    // Reset during CHECK: outputs drop at once and no frame_done follows.
    set_vs(1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    set_keys(48'h07);
    set_vs(1'b1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("midrst.valid", 32'({ifa.valid, ifb.valid}), 32'd0);
    chk("midrst.pos", 32'(ifa.pos_x | ifa.pos_y | ifb.pos_x | ifb.pos_y), 32'd0);
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      chk("midrst.no_done", 32'({ifa.frame_done, ifb.frame_done}), 32'd0);
    end
    reset_and_load("wall", 6, 200, 300, 300);

    // Left wall clamp.
    run_frame("left1", 48'h04, mk(4, 200, 300, 300, 2'b01, 2'b00),
              mk(5, 200, 300, 300, 2'b00, 2'b00));
    run_frame("left2", 48'h04, mk(4, 200, 300, 300, 2'b01, 2'b00),
              mk(4, 200, 300, 300, 2'b01, 2'b00));
    run_frame("left3", 48'h04, mk(4, 200, 300, 300, 2'b01, 2'b00),
              mk(4, 200, 300, 300, 2'b01, 2'b00));
    run_frame("leftrel", 48'h0, mk(4, 200, 300, 300, 2'b00, 2'b00),
              mk(4, 200, 300, 300, 2'b00, 2'b00));

    // Head-on approach: overlap reverts both sprites.
    reset_and_load("coll", 100, 200, 112, 200);
    run_frame("coll1", 48'h50_07, mk(100, 200, 112, 200, 2'b00, 2'b11),
              mk(101, 200, 111, 200, 2'b00, 2'b00));
    run_frame("coll2", 48'h50_07, mk(100, 200, 112, 200, 2'b00, 2'b11),
              mk(101, 200, 111, 200, 2'b00, 2'b11));
    run_frame("coll3", 48'h50_07, mk(100, 200, 112, 200, 2'b00, 2'b11),
              mk(102, 200, 110, 200, 2'b00, 2'b00));
    run_frame("coll4", 48'h0, mk(100, 200, 112, 200, 2'b00, 2'b00),
              mk(102, 200, 110, 200, 2'b00, 2'b00));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
